// File: rtl/comparator_pkg.sv
// Shared encodings for the registered magnitude comparator.
package comparator_pkg;

  // One-hot result encodings driven on o_f.
  localparam logic [2:0] F_GT   = 3'b100;
  localparam logic [2:0] F_EQ   = 3'b010;
  localparam logic [2:0] F_LT   = 3'b001;
  localparam logic [2:0] F_NONE = 3'b000;

  // Bit positions of each relation within o_f.
  localparam int unsigned F_GT_BIT = 2;
  localparam int unsigned F_EQ_BIT = 1;
  localparam int unsigned F_LT_BIT = 0;

endpackage

// File: rtl/comparator_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module comparator_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear first, otherwise step unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/comparator_unit.sv
// Registered signed/unsigned magnitude comparator with one-hot result and max/min outputs.
// Optional per-relation sample counters are built when COMPARATOR_STATS_EN is defined.
module comparator_unit
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic [2:0]       o_f,
  output logic [WIDTH-1:0] o_max,
`ifdef COMPARATOR_STATS_EN
  output logic [WIDTH-1:0] o_min,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_gt_cnt,
  output logic [CNT_W-1:0] o_eq_cnt,
  output logic [CNT_W-1:0] o_lt_cnt
`else
  output logic [WIDTH-1:0] o_min
`endif
);

  logic [WIDTH-1:0] msb_mask;
  logic [WIDTH-1:0] a_key, b_key;
  logic [2:0]       f_d, f_q;
  logic [WIDTH-1:0] max_d, max_q;
  logic [WIDTH-1:0] min_d, min_q;
  logic             valid_q;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  always_comb begin
    msb_mask            = '0;
    msb_mask[WIDTH-1]   = i_signed;
    a_key               = i_a ^ msb_mask;
    b_key               = i_b ^ msb_mask;
    if (a_key > b_key) begin
      f_d   = F_GT;
      max_d = i_a;
      min_d = i_b;
    end else if (a_key == b_key) begin
      f_d   = F_EQ;
      max_d = i_a;
      min_d = i_a;
    end else begin
      f_d   = F_LT;
      max_d = i_b;
      min_d = i_a;
    end
  end

  // Result registers load only on a valid sample, otherwise they hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      f_q     <= F_NONE;
      max_q   <= '0;
      min_q   <= '0;
    end else begin
      valid_q <= i_valid;
      if (i_valid) begin
        f_q   <= f_d;
        max_q <= max_d;
        min_q <= min_d;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_f     = f_q;
  assign o_max   = max_q;
  assign o_min   = min_q;

`ifdef COMPARATOR_STATS_EN
  logic inc_gt, inc_eq, inc_lt;

  // Count the relation of each accepted sample; the counter itself gives clear priority.
  always_comb begin
    inc_gt = i_valid & f_d[F_GT_BIT];
    inc_eq = i_valid & f_d[F_EQ_BIT];
    inc_lt = i_valid & f_d[F_LT_BIT];
  end

  comparator_sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .inc    (inc_gt),
    .clr    (i_cnt_clr),
    .cnt    (o_gt_cnt)
  );

  comparator_sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .inc    (inc_eq),
    .clr    (i_cnt_clr),
    .cnt    (o_eq_cnt)
  );

  comparator_sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .inc    (inc_lt),
    .clr    (i_cnt_clr),
    .cnt    (o_lt_cnt)
  );
`else
  // Without the counters CNT_W has no role; still reject a nonsensical value.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_comparator_unit.sv
// Scoreboard bench for comparator_unit; counter checks run when COMPARATOR_STATS_EN is defined.
module tb_comparator_unit;

  localparam int W  = 3;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         o_valid;
  logic [2:0]   o_f;
  logic [W-1:0] o_max;
  logic [W-1:0] o_min;
`ifdef COMPARATOR_STATS_EN
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] gt_cnt, eq_cnt, lt_cnt;
`endif

  always #5 clk = ~clk;

  comparator_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_signed(sgn),
    .i_a     (a),
    .i_b     (b),
    .o_valid (o_valid),
    .o_f     (o_f),
    .o_max   (o_max),
`ifdef COMPARATOR_STATS_EN
    .o_min   (o_min),
    .i_cnt_clr(cnt_clr),
    .o_gt_cnt(gt_cnt),
    .o_eq_cnt(eq_cnt),
    .o_lt_cnt(lt_cnt)
`else
    .o_min   (o_min)
`endif
  );

  typedef struct packed {
    logic [2:0]   f;
    logic [W-1:0] mx;
    logic [W-1:0] mn;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference relation computed on integers.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic s);
    int   av, bv;
    exp_t e;
    av = (s && ma[W-1]) ? int'(ma) - (1 << W) : int'(ma);
    bv = (s && mb[W-1]) ? int'(mb) - (1 << W) : int'(mb);
    if (av > bv)       e = '{f: 3'b100, mx: ma, mn: mb};
    else if (av == bv) e = '{f: 3'b010, mx: ma, mn: ma};
    else               e = '{f: 3'b001, mx: mb, mn: ma};
    return e;
  endfunction

  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic ds);
    @(negedge clk);
    valid = 1'b1;
    a     = da;
    b     = db;
    sgn   = ds;
    last_exp = model(da, db, ds);
    q.push_back(last_exp);
  endtask

  // Idle cycles drive unknown operands, which must not disturb the held outputs.
  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    a     = 'x;
    b     = 'x;
    sgn   = 1'bx;
  endtask

  // Scoreboard: every valid result pops one expectation.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (q.size() == 0) begin
        check_eq("spurious_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("o_f", 32'(o_f), 32'(e.f));
        check_eq("o_max", 32'(o_max), 32'(e.mx));
        check_eq("o_min", 32'(o_min), 32'(e.mn));
        check_eq("onehot", 32'($countones(o_f)), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_f", 32'(o_f), 32'd0);
    check_eq("rst_max", 32'(o_max), 32'd0);
    check_eq("rst_min", 32'(o_min), 32'd0);
    rst_n = 1'b1;

    drive(3'b100, 3'b001, 1'b0);
    drive(3'b000, 3'b000, 1'b0);
    drive(3'b001, 3'b100, 1'b0);
    drive(3'b111, 3'b001, 1'b1);
    drive(3'b111, 3'b001, 1'b0);
    drive(3'b100, 3'b011, 1'b1);
    drive(3'b101, 3'b101, 1'b1);
    idle();
    @(negedge clk);
    #1;
    check_eq("hold_valid", 32'(o_valid), 32'd0);
    check_eq("hold_f", 32'(o_f), 32'(last_exp.f));
    check_eq("hold_max", 32'(o_max), 32'(last_exp.mx));
    check_eq("hold_min", 32'(o_min), 32'(last_exp.mn));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) idle();
      else drive(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Mid-stream reset: the sample just driven is in flight and must vanish.
    drive(3'b010, 3'b110, 1'b0);
    drive(3'b101, 3'b011, 1'b0);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    void'(q.pop_back());
    #1;
    check_eq("midrst_valid", 32'(o_valid), 32'd0);
    check_eq("midrst_f", 32'(o_f), 32'd0);
    check_eq("midrst_max", 32'(o_max), 32'd0);
    check_eq("midrst_min", 32'(o_min), 32'd0);
    @(posedge clk);
    #1;
    check_eq("inrst_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b011, 3'b010, 1'b1);
    idle();

`ifdef COMPARATOR_STATS_EN
    check_eq("cnt_rst_gt", 32'(gt_cnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(3'b101, 3'b001, 1'b0);
      @(negedge clk);
      valid = 1'b0;
      #1;
      check_eq("cnt_gt_step", 32'(gt_cnt), (i + 2 > 3) ? 32'd3 : 32'(i + 2));
    end
    check_eq("cnt_eq_zero", 32'(eq_cnt), 32'd0);
    check_eq("cnt_lt_zero", 32'(lt_cnt), 32'd0);
    drive(3'b010, 3'b010, 1'b0);
    drive(3'b001, 3'b011, 1'b0);
    idle();
    #1;
    check_eq("cnt_eq_one", 32'(eq_cnt), 32'd1);
    check_eq("cnt_lt_one", 32'(lt_cnt), 32'd1);
    drive(3'b110, 3'b110, 1'b0);
    cnt_clr = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    cnt_clr = 1'b0;
    #1;
    check_eq("clr_gt", 32'(gt_cnt), 32'd0);
    check_eq("clr_eq", 32'(eq_cnt), 32'd0);
    check_eq("clr_lt", 32'(lt_cnt), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check_eq("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
